// File: rtl/mvm_driver.sv
// Host-side initiator for the MVM: buffers a gappy host word stream, replays it as gap-free load bursts, starts the unit,
// captures K results and returns them. Control outputs are registered; in/out/job streams stall cleanly on valid/ready.
module mvm_driver #(
  parameter int K            = 8,
  parameter int B            = 8,
  parameter int RESULT_DELAY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           job_valid,
  output logic           job_ready,
  input  logic           job_keep_matrix,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           loadMatrix,
  output logic           loadVector,
  output logic           start,
  output logic [B-1:0]   data_to_mvm,
  input  logic           done,
  input  logic [2*B-1:0] data_from_mvm
);

  localparam int KK = K * K;
  localparam int NW = KK + K;
  localparam int CW = $clog2(NW + 1);
  localparam int AW = $clog2(NW);
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY + 1) : 1;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_KK    = CW'(KK);
  localparam logic [CW-1:0] C_KK_M1 = CW'(KK - 1);
  localparam logic [CW-1:0] C_NW_M1 = CW'(NW - 1);
  localparam logic [CW-1:0] C_K     = CW'(K);
  localparam logic [CW-1:0] C_K_M1  = CW'(K - 1);
  localparam logic [AW-1:0] A_KK    = AW'(KK);
  localparam logic [DW-1:0] D_INIT  = DW'(RESULT_DELAY);
  localparam logic [DW-1:0] D_ONE   = DW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL_M, S_FILL_V, S_SEND_M, S_SEND_V, S_START, S_WAIT_DONE, S_CAPTURE, S_DRAIN
  } state_t;

  typedef struct packed {
    logic job_ready;
    logic in_ready;
    logic out_valid;
    logic busy;
    logic load_matrix;
    logic load_vector;
    logic start;
  } ctl_t;

  state_t          state, state_nxt;
  ctl_t            ctl_q, ctl_d;
  logic [B-1:0]    data_q, data_nxt;
  logic [CW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   snd_cnt, snd_nxt;
  logic [CW-1:0]   cap_ptr, cap_nxt;
  logic [CW-1:0]   rd_ptr, rd_nxt;
  logic [DW-1:0]   dly, dly_nxt;
  logic            eff_keep, eff_keep_nxt;
  logic            matrix_loaded, ml_nxt;
  logic            wr_en, cap_en;
  logic [RW-1:0]   cap_idx;

  logic [B-1:0]    buf_mem [NW];
  logic [2*B-1:0]  res_mem [K];

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    snd_nxt      = snd_cnt;
    cap_nxt      = cap_ptr;
    rd_nxt       = rd_ptr;
    dly_nxt      = dly;
    eff_keep_nxt = eff_keep;
    ml_nxt       = matrix_loaded;
    data_nxt     = '0;
    wr_en        = 1'b0;
    cap_en       = 1'b0;
    cap_idx      = cap_ptr[RW-1:0];
    ctl_d        = '0;

    case (state)
      S_IDLE: begin
        if (job_valid && ctl_q.job_ready) begin
          // A keep request is only honoured once a matrix has actually reached the MVM.
          eff_keep_nxt = job_keep_matrix & matrix_loaded;
          if (job_keep_matrix & matrix_loaded) begin
            state_nxt  = S_FILL_V;
            wr_ptr_nxt = C_KK;
          end else begin
            state_nxt  = S_FILL_M;
            wr_ptr_nxt = '0;
          end
        end
      end
      S_FILL_M: begin
        if (in_valid && ctl_q.in_ready) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + C_ONE;
          if (wr_ptr == C_KK_M1) state_nxt = S_FILL_V;
        end
      end
      S_FILL_V: begin
        if (in_valid && ctl_q.in_ready) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + C_ONE;
          if (wr_ptr == C_NW_M1) begin
            snd_nxt = '0;
            if (eff_keep) begin
              state_nxt         = S_SEND_V;
              ctl_d.load_vector = 1'b1;
            end else begin
              state_nxt         = S_SEND_M;
              ctl_d.load_matrix = 1'b1;
            end
          end
        end
      end
      S_SEND_M: begin
        if (snd_cnt == C_KK) begin
          state_nxt         = S_SEND_V;
          ctl_d.load_vector = 1'b1;
          snd_nxt           = '0;
          ml_nxt            = 1'b1;
        end else begin
          data_nxt = buf_mem[snd_cnt[AW-1:0]];
          snd_nxt  = snd_cnt + C_ONE;
        end
      end
      S_SEND_V: begin
        if (snd_cnt == C_K) begin
          state_nxt   = S_START;
          ctl_d.start = 1'b1;
        end else begin
          data_nxt = buf_mem[A_KK + snd_cnt[AW-1:0]];
          snd_nxt  = snd_cnt + C_ONE;
        end
      end
      S_START: state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done) begin
          state_nxt = S_CAPTURE;
          dly_nxt   = D_INIT;
          cap_nxt   = '0;
          rd_nxt    = '0;
          // With zero delay the first result is already on the bus alongside done.
          if (RESULT_DELAY == 0) begin
            cap_en  = 1'b1;
            cap_idx = '0;
            cap_nxt = C_ONE;
            if (K == 1) state_nxt = S_DRAIN;
          end
        end
      end
      S_CAPTURE: begin
        if (dly > D_ONE) begin
          dly_nxt = dly - D_ONE;
        end else begin
          cap_en  = 1'b1;
          cap_nxt = cap_ptr + C_ONE;
          if (cap_ptr == C_K_M1) begin
            state_nxt = S_DRAIN;
            rd_nxt    = '0;
          end
        end
      end
      S_DRAIN: begin
        if (ctl_q.out_valid && out_ready) begin
          if (rd_ptr == C_K_M1) state_nxt = S_IDLE;
          else                  rd_nxt    = rd_ptr + C_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ctl_d.job_ready = (state_nxt == S_IDLE);
    ctl_d.in_ready  = (state_nxt == S_FILL_M) || (state_nxt == S_FILL_V);
    ctl_d.out_valid = (state_nxt == S_DRAIN);
    ctl_d.busy      = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ctl_q         <= '0;
      data_q        <= '0;
      wr_ptr        <= '0;
      snd_cnt       <= '0;
      cap_ptr       <= '0;
      rd_ptr        <= '0;
      dly           <= '0;
      eff_keep      <= 1'b0;
      matrix_loaded <= 1'b0;
    end else begin
      state         <= state_nxt;
      ctl_q         <= ctl_d;
      data_q        <= data_nxt;
      wr_ptr        <= wr_ptr_nxt;
      snd_cnt       <= snd_nxt;
      cap_ptr       <= cap_nxt;
      rd_ptr        <= rd_nxt;
      dly           <= dly_nxt;
      eff_keep      <= eff_keep_nxt;
      matrix_loaded <= ml_nxt;
    end
  end

  // Storage carries no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en)  buf_mem[wr_ptr[AW-1:0]] <= in_data;
    if (cap_en) res_mem[cap_idx]        <= data_from_mvm;
  end

  assign job_ready   = ctl_q.job_ready;
  assign in_ready    = ctl_q.in_ready;
  assign out_valid   = ctl_q.out_valid;
  assign busy        = ctl_q.busy;
  assign loadMatrix  = ctl_q.load_matrix;
  assign loadVector  = ctl_q.load_vector;
  assign start       = ctl_q.start;
  assign data_to_mvm = data_q;
  assign out_data    = ctl_q.out_valid ? res_mem[rd_ptr[RW-1:0]] : '0;
  assign out_last    = ctl_q.out_valid && (rd_ptr == C_K_M1);

endmodule

// File: tb/tb_mvm_driver.sv
// Directed bench for mvm_driver (K=8, B=8): table of jobs with hand-computed results plus
// stall/done-injection and mid-burst reset sequences, against a small behavioural MVM.
module tb_mvm_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic        job_keep_matrix = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        loadMatrix;
  logic        loadVector;
  logic        start;
  logic [7:0]  data_to_mvm;
  logic        done = 1'b0;
  logic [15:0] data_from_mvm = 16'hDEAD;

  always #5 clk = ~clk;

  mvm_driver #(.K(8), .B(8), .RESULT_DELAY(1)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_keep_matrix(job_keep_matrix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
    .data_to_mvm(data_to_mvm), .done(done), .data_from_mvm(data_from_mvm)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake monitor and behavioural MVM.
  int hs_cnt = 0, lm_cnt = 0, lv_cnt = 0, st_cnt = 0, pulse_bad = 0, idle_bad = 0;
  int inj_req = 0, inj_ack = 0;
  int m_mode = 0, m_cnt = 0, mc = 0, np = 0, acc = 0;
  logic [7:0]  amat [64];
  logic [7:0]  xvec [8];
  logic [15:0] yres [8];

  always @(posedge clk) if (!reset && in_valid && in_ready) hs_cnt++;

  always @(posedge clk) begin
    #1;
    done = 1'b0;
    data_from_mvm = 16'hDEAD;
    if (reset) begin
      m_mode = 0; m_cnt = 0; mc = 0;
    end else begin
      np = int'(loadMatrix) + int'(loadVector) + int'(start);
      if (np > 1) pulse_bad++;
      if (m_mode == 1) begin
        if (np != 0) pulse_bad++;
        amat[m_cnt] = data_to_mvm; m_cnt++;
        if (m_cnt == 64) m_mode = 0;
      end else if (m_mode == 2) begin
        if (np != 0) pulse_bad++;
        xvec[m_cnt] = data_to_mvm; m_cnt++;
        if (m_cnt == 8) m_mode = 0;
      end else if (data_to_mvm != 8'h00) idle_bad++;
      if (loadMatrix) begin lm_cnt++; m_mode = 1; m_cnt = 0; end
      if (loadVector) begin lv_cnt++; m_mode = 2; m_cnt = 0; end
      if (start) begin
        st_cnt++;
        for (int i = 0; i < 8; i++) begin
          acc = 0;
          for (int j = 0; j < 8; j++) acc += $signed(amat[i*8+j]) * $signed(xvec[j]);
          yres[i] = acc[15:0];
        end
        mc = 1;
      end else if (mc != 0) begin
        mc++;
        if (mc == 5) done = 1'b1;
        if (mc >= 6) data_from_mvm = yres[mc-6];
        if (mc == 13) mc = 0;
      end
      if (inj_req != inj_ack) begin done = 1'b1; inj_ack = inj_req; end
    end
  end

  typedef struct packed {
    logic         keep;
    logic [1:0]   amode;   // 0 identity, 1 constant afill, 2 row r filled with r+1
    logic [7:0]   afill;
    logic [63:0]  x;       // x[0] in the low byte
    logic [127:0] y;       // y[0] in the low halfword
    logic [6:0]   words;
    logic         lm;
    logic [1:0]   gap;
  } vec_t;

  function automatic logic [7:0] a_elem(input logic [1:0] m, input logic [7:0] f, input int r, input int c);
    if (m == 2'd0) return (r == c) ? 8'd1 : 8'd0;
    if (m == 2'd1) return f;
    return 8'(r + 1);
  endfunction

  task automatic run_job(input vec_t v, input int stall_at, input int abort_at, input string tag);
    logic [7:0] w [72];
    int nw, idx, nres, cyc, sm, stalls, gap;
    int hs0, lm0, lv0, st0, pb0, ib0;
    bit accepted;
    nw = int'(v.words); idx = 0; nres = 0; cyc = 0; sm = -1; stalls = 0; accepted = 0;
    gap = int'(v.gap);
    hs0 = hs_cnt; lm0 = lm_cnt; lv0 = lv_cnt; st0 = st_cnt; pb0 = pulse_bad; ib0 = idle_bad;
    if (nw == 72) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) w[r*8+c] = a_elem(v.amode, v.afill, r, c);
      for (int i = 0; i < 8; i++) w[64+i] = v.x[8*i +: 8];
    end else begin
      for (int i = 0; i < 8; i++) w[i] = v.x[8*i +: 8];
    end

    while (nres < 8 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!accepted) begin
        job_valid = 1'b1; job_keep_matrix = v.keep;
        if (job_ready) accepted = 1;
      end else begin
        job_valid = 1'b0;
      end
      in_valid = ((cyc % gap) == 0);
      in_data  = (idx < nw) ? w[idx] : 8'h55;
      if (in_valid && in_ready) idx++;
      if (loadMatrix) sm = 0;
      else if (sm >= 0) sm++;
      if (abort_at >= 0 && sm == abort_at) begin
        reset = 1'b1;
        break;
      end
      if (out_valid && nres == stall_at && stalls < 5) begin
        out_ready = 1'b0;
        if (stalls == 0) inj_req++;
        chk($sformatf("%s_hold_data%0d", tag, stalls), out_data, v.y[16*nres +: 16]);
        chk($sformatf("%s_hold_jrdy%0d", tag, stalls), job_ready, 0);
        stalls++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          chk($sformatf("%s_y%0d", tag, nres), out_data, v.y[16*nres +: 16]);
          chk($sformatf("%s_last%0d", tag, nres), out_last, (nres == 7));
          nres++;
        end
      end
    end

    if (abort_at >= 0) begin
      chk({tag, "_abort_point"}, sm, abort_at);
      @(negedge clk);
      chk({tag, "_rst_ctl"}, {job_ready, in_ready, out_valid, out_last, busy, loadMatrix, loadVector, start}, 0);
      chk({tag, "_rst_data"}, {out_data, data_to_mvm}, 0);
      reset = 1'b0; job_valid = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_rst_jrdy"}, job_ready, 1);
      return;
    end

    if (nres < 8) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d results expected 8", tag, nres);
    end
    @(negedge clk);
    job_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_jrdy_end"}, job_ready, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_words"}, hs_cnt - hs0, nw);
    chk({tag, "_loadm"}, lm_cnt - lm0, int'(v.lm));
    chk({tag, "_loadv"}, lv_cnt - lv0, 1);
    chk({tag, "_start"}, st_cnt - st0, 1);
    chk({tag, "_pulse"}, pulse_bad - pb0, 0);
    chk({tag, "_idle_dat"}, idle_bad - ib0, 0);
  endtask

  localparam logic [63:0]  X_SEQ = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [127:0] Y_SEQ = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

  vec_t vecs [6];
  vec_t v_stall, v_abort, v_after;

  initial begin
    vecs[0] = '{keep:1'b1, amode:2'd1, afill:8'hFF, x:{8{8'h7F}}, y:{8{16'hFC08}}, words:7'd72, lm:1'b1, gap:2'd1};
    vecs[1] = '{keep:1'b0, amode:2'd0, afill:8'h00, x:X_SEQ, y:Y_SEQ, words:7'd72, lm:1'b1, gap:2'd1};
    vecs[2] = '{keep:1'b0, amode:2'd0, afill:8'h00, x:X_SEQ, y:Y_SEQ, words:7'd72, lm:1'b1, gap:2'd3};
    vecs[3] = '{keep:1'b1, amode:2'd0, afill:8'h00, x:{8{8'd2}}, y:{8{16'h0002}}, words:7'd8, lm:1'b0, gap:2'd1};
    vecs[4] = '{keep:1'b0, amode:2'd2, afill:8'h00, x:{8{8'd1}},
                y:{16'd64, 16'd56, 16'd48, 16'd40, 16'd32, 16'd24, 16'd16, 16'd8}, words:7'd72, lm:1'b1, gap:2'd2};
    vecs[5] = '{keep:1'b1, amode:2'd2, afill:8'h00, x:X_SEQ,
                y:{16'd288, 16'd252, 16'd216, 16'd180, 16'd144, 16'd108, 16'd72, 16'd36}, words:7'd8, lm:1'b0, gap:2'd1};
    v_stall = '{keep:1'b1, amode:2'd2, afill:8'h00, x:{8{8'd2}},
                y:{16'd128, 16'd112, 16'd96, 16'd80, 16'd64, 16'd48, 16'd32, 16'd16}, words:7'd8, lm:1'b0, gap:2'd1};
    v_abort = '{keep:1'b0, amode:2'd0, afill:8'h00, x:X_SEQ, y:Y_SEQ, words:7'd72, lm:1'b1, gap:2'd1};
    v_after = '{keep:1'b1, amode:2'd0, afill:8'h00, x:{8{8'd3}}, y:{8{16'h0003}}, words:7'd72, lm:1'b1, gap:2'd1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {job_ready, in_ready, out_valid, out_last, busy, loadMatrix, loadVector, start}, 0);
    chk("reset_data", {out_data, data_to_mvm}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_jrdy_after", job_ready, 1);
    chk("reset_busy_after", busy, 0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], -1, -1, $sformatf("v%0d", i));
    run_job(v_stall, 3, -1, "stall");
    repeat (4) @(negedge clk);
    chk("stall_idle_hold", {busy, in_ready, out_valid}, 0);
    run_job(v_abort, -1, 20, "abort");
    run_job(v_after, -1, -1, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvm_driver.md
Name: mvm_driver

Overview:
Host-side initiator for the matrix-vector multiply unit (mvm_8_8_8_1 and its parameterised variants). It accepts a job descriptor and a gappy valid/ready word stream, buffers the words, then replays them to the MVM as gap-free loadMatrix/loadVector bursts and issues start. After done, it captures the K results from the MVM output bus and returns them to the host on a valid/ready stream. It sits between the testbench/host fabric and the mvm instance.

Parameters:
K, 8, matrix dimension (K×K matrix, K-element vector and result)
B, 8, input word width; results are 2*B wide
RESULT_DELAY, 1, cycles from the done pulse to the first result word on data_from_mvm; the remaining K-1 results follow on consecutive cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
job_valid  in  1  job descriptor valid
job_ready  out  1  driver idle and able to accept a job
job_keep_matrix  in  1  1 = reuse the matrix already in the MVM; send the vector only
in_valid  in  1  host word valid
in_ready  out  1  driver accepting host words
in_data  in  B  signed host word, row-major matrix first, then vector
out_valid  out  1  result word valid
out_ready  in  1  host accepts result
out_data  out  2B  signed result y[i], i = 0..K-1 in order
out_last  out  1  high with y[K-1]
busy  out  1  high whenever the state is not IDLE
loadMatrix  out  1  one-cycle pulse to the MVM
loadVector  out  1  one-cycle pulse to the MVM
start  out  1  one-cycle pulse to the MVM
data_to_mvm  out  B  MVM data_in
done  in  1  MVM done pulse
data_from_mvm  in  2B  MVM data_out

Behaviour:
- Reset: all outputs 0; state IDLE; matrix_loaded=0; all counters 0. Reset wins over every other event and may be applied in any state. Buffer contents are don't-care after reset.
- Buffer: K*K+K words of B bits. Matrix occupies addresses 0..K*K-1, vector occupies K*K..K*K+K-1. Result buffer: K words of 2B bits.
- IDLE: job_ready=1. On job_valid, latch eff_keep = job_keep_matrix & matrix_loaded. If eff_keep=1, go to FILL_V with write pointer K*K. Otherwise go to FILL_M with write pointer 0.
- FILL_M / FILL_V: in_ready=1. A word is written on each cycle with in_valid&in_ready, and the pointer increments.
  - When the pointer reaches K*K in FILL_M, go to FILL_V.
  - After the write at pointer K*K+K-1, go to SEND_M if eff_keep=0, otherwise SEND_V.
- SEND_M: cycle 0 asserts loadMatrix=1 with data_to_mvm=0. Cycles 1..K*K drive buffer[0..K*K-1], one word per cycle, with no gaps. Then set matrix_loaded=1 and go to SEND_V.
- SEND_V: cycle 0 asserts loadVector=1. Cycles 1..K drive buffer[K*K..K*K+K-1]. Then go to START.
- START: start=1 for exactly one cycle; data_to_mvm=0; go to WAIT_DONE.
- WAIT_DONE: on done, load the delay counter with RESULT_DELAY and go to CAPTURE.
  - done in any other state is ignored.
- CAPTURE: count RESULT_DELAY cycles after the done cycle. Then sample data_from_mvm on K consecutive cycles into result[0..K-1]. Then go to DRAIN.
- DRAIN: out_valid=1 and out_data=result[rd_ptr]. rd_ptr advances on out_valid&out_ready. out_last=(rd_ptr==K-1). On the handshake of the last word, go to IDLE.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- data_to_mvm=0 whenever the driver is not in a send data cycle. Pulses never overlap. job_ready=0, in_ready=0 and out_valid=0 outside their own states.
- A job with job_keep_matrix=1 issued right after reset is treated as a full load: it consumes K*K+K words and asserts loadMatrix.
- Arithmetic: words pass through unmodified; the driver does no signed math. Counters are sized with $clog2(K*K+K+1).

Test Plan:
- Full job, A=identity, x=1..8, in_valid always 1, out_ready=1 -> loadMatrix pulse, 64 gap-free words, loadVector pulse, 8 words, start pulse; results 1,2,...,8; out_last only on the 8th result; job_ready back to 1.
- Same job with in_valid high every 3rd cycle -> MVM bursts still gap-free and results identical.
- Follow-up job with keep_matrix=1 and x=all 2 -> no loadMatrix pulse, exactly 8 words consumed, results all 16'h0002.
- A=all 8'hFF (-1), x=all 8'h7F -> every result 16'hFC08 (-1016); also keep_matrix=1 immediately after reset -> 72 words consumed and loadMatrix asserted.
- out_ready low for 5 cycles during DRAIN -> out_data held stable; job_ready stays 0 until the 8th handshake; a done pulse injected during DRAIN is ignored.
- Reset asserted on cycle 20 of SEND_M -> next cycle all outputs 0, state IDLE, matrix_loaded=0; the following keep_matrix=1 job performs a full load.
